// File: rtl/beep_sequencer.sv
// Turns single-cycle event strobes into timed beeps: HIGH_CYC cycles high, GAP_CYC low.
// Strobes arriving while a beep is running are counted (saturating) and replayed in order.
//
// state  | meaning
// -------+-----------------------------------------------
// S_IDLE | no beep running, z=0
// S_HIGH | beep active, z=1, timer counts HIGH_CYC-1..0
// S_GAP  | enforced low gap, z=0, timer counts GAP_CYC-1..0
module beep_sequencer #(
   parameter int HIGH_CYC = 4,
   parameter int GAP_CYC  = 2,
   parameter int PEND_W   = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              w,
   input  logic              clr,
   output logic              z,
   output logic              busy,
   output logic [PEND_W-1:0] pending,
   output logic              ovf
);

   localparam int MAX_CYC = (HIGH_CYC > GAP_CYC) ? HIGH_CYC : GAP_CYC;
   localparam int TW      = $clog2(MAX_CYC) + 1;
   localparam logic [TW-1:0]     HIGH_LOAD = TW'(HIGH_CYC - 1);
   localparam logic [TW-1:0]     GAP_LOAD  = TW'(GAP_CYC - 1);
   localparam logic [PEND_W-1:0] PEND_MAX  = '1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_HIGH = 2'd1,
      S_GAP  = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [TW-1:0]     timer_q, timer_d;
   logic [PEND_W-1:0] pending_q, pending_d;
   logic              ovf_q, ovf_d;
   logic              start;

   always_comb begin
      start = ((state_q == S_IDLE) || ((state_q == S_GAP) && (timer_q == '0)))
              && ((pending_q != '0) || w);

      state_d   = state_q;
      timer_d   = timer_q;
      pending_d = pending_q;
      ovf_d     = ovf_q;

      if (clr) begin
         state_d   = S_IDLE;
         timer_d   = '0;
         pending_d = '0;
         ovf_d     = 1'b0;
      end else begin
         if (start) begin
            state_d = S_HIGH;
            timer_d = HIGH_LOAD;
         end else begin
            case (state_q)
               S_HIGH: begin
                  if (timer_q == '0) begin
                     state_d = S_GAP;
                     timer_d = GAP_LOAD;
                  end else begin
                     timer_d = timer_q - TW'(1);
                  end
               end
               S_GAP: begin
                  if (timer_q == '0) begin
                     state_d = S_IDLE;
                     timer_d = '0;
                  end else begin
                     timer_d = timer_q - TW'(1);
                  end
               end
               default: begin
                  state_d = S_IDLE;
                  timer_d = '0;
               end
            endcase
         end

         // A strobe consumed by start in the same cycle never enters the queue.
         if (w && !start) begin
            if (pending_q == PEND_MAX) begin
               ovf_d = 1'b1;
            end else begin
               pending_d = pending_q + PEND_W'(1);
            end
         end else if (!w && start) begin
            pending_d = pending_q - PEND_W'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= S_IDLE;
         timer_q   <= '0;
         pending_q <= '0;
         ovf_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         timer_q   <= timer_d;
         pending_q <= pending_d;
         ovf_q     <= ovf_d;
      end
   end

   assign z       = (state_q == S_HIGH);
   assign busy    = (state_q != S_IDLE) || (pending_q != '0);
   assign pending = pending_q;
   assign ovf     = ovf_q;

endmodule

// File: tb/tb_beep_sequencer.sv
// Directed self-checking bench for beep_sequencer at default parameters.
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
module tb_beep_sequencer;

   logic       clk;
   logic       reset;
   logic       w;
   logic       clr;
   logic       z;
   logic       busy;
   logic [2:0] pending;
   logic       ovf;

   int n_cmp;
   int n_err;

   beep_sequencer #(.HIGH_CYC(4), .GAP_CYC(2), .PEND_W(3)) dut (
      .clk     (clk),
      .reset   (reset),
      .w       (w),
      .clr     (clr),
      .z       (z),
      .busy    (busy),
      .pending (pending),
      .ovf     (ovf)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Holds w/clr for one clock edge, then returns 1 unit after that edge.
   task automatic step(input logic wv, input logic cv);
      w   = wv;
      clr = cv;
      @(posedge clk);
      #1;
      w   = 1'b0;
      clr = 1'b0;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      w     = 1'b0;
      clr   = 1'b0;
      #12;
      n_cmp++;
      if ({z, busy, pending, ovf} !== 6'b0) begin
         n_err++;
         $display("FAIL reset_state: got z=%b busy=%b pending=%0d ovf=%b, want all 0", z, busy, pending, ovf);
      end
      reset = 1'b0;
      step(1'b0, 1'b0);
      n_cmp++;
      if ({z, busy, pending, ovf} !== 6'b0) begin
         n_err++;
         $display("FAIL reset_release: got z=%b busy=%b pending=%0d ovf=%b, want all 0", z, busy, pending, ovf);
      end
   endtask

   // One strobe: samples cover cycles 11..17 (bit i = cycle 11+i).
   task automatic test_single;
      logic [6:0] exp_z;
      logic [6:0] exp_busy;
      exp_z    = 7'b0001111;
      exp_busy = 7'b0111111;
      step(1'b1, 1'b0);
      for (int i = 0; i < 7; i++) begin
         n_cmp++;
         if (z !== exp_z[i] || busy !== exp_busy[i] || pending !== 3'd0) begin
            n_err++;
            $display("FAIL single cyc%0d: got z=%b busy=%b pending=%0d, want z=%b busy=%b pending=0",
                     11 + i, z, busy, pending, exp_z[i], exp_busy[i]);
         end
         step(1'b0, 1'b0);
      end
   endtask

   // Three strobes at cycles 10,11,12; z sampled for cycles 11..29.
   task automatic test_three;
      logic [18:0] exp_z;
      logic [18:0] exp_busy;
      logic [2:0]  exp_pend [3];
      exp_z       = 19'h0F3CF;
      exp_busy    = 19'h3FFFF;
      exp_pend[0] = 3'd0;
      exp_pend[1] = 3'd1;
      exp_pend[2] = 3'd2;
      for (int i = 0; i < 19; i++) begin
         step((i < 3) ? 1'b1 : 1'b0, 1'b0);
         if (i < 3) begin
            n_cmp++;
            if (pending !== exp_pend[i]) begin
               n_err++;
               $display("FAIL three_pending cyc%0d: got %0d, want %0d", 11 + i, pending, exp_pend[i]);
            end
         end
         n_cmp++;
         if (z !== exp_z[i] || busy !== exp_busy[i]) begin
            n_err++;
            $display("FAIL three_z cyc%0d: got z=%b busy=%b, want z=%b busy=%b",
                     11 + i, z, busy, exp_z[i], exp_busy[i]);
         end
      end
   endtask

   // Ten consecutive strobes from idle: one is consumed by the start at the
   // end of the first gap, the queue fills to 7 and the tenth is dropped.
   task automatic test_saturate;
      logic [2:0] exp_pend [10];
      int         beeps;
      logic       prev_z;
      int         budget;
      exp_pend = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd5, 3'd6, 3'd7, 3'd7};
      beeps  = 0;
      prev_z = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step(1'b1, 1'b0);
         if (z && !prev_z) beeps++;
         prev_z = z;
         n_cmp++;
         if (pending !== exp_pend[i] || ovf !== (i == 9)) begin
            n_err++;
            $display("FAIL sat_step%0d: got pending=%0d ovf=%b, want pending=%0d ovf=%b",
                     i, pending, ovf, exp_pend[i], (i == 9));
         end
      end
      budget = 0;
      while (busy && budget < 200) begin
         step(1'b0, 1'b0);
         if (z && !prev_z) beeps++;
         prev_z = z;
         budget++;
      end
      n_cmp++;
      if (busy !== 1'b0) begin
         n_err++;
         $display("FAIL sat_timeout: busy still %b after %0d cycles, want 0", busy, budget);
      end
      n_cmp++;
      if (beeps != 9) begin
         n_err++;
         $display("FAIL sat_beeps: got %0d beeps, want 9", beeps);
      end
      n_cmp++;
      if (ovf !== 1'b1) begin
         n_err++;
         $display("FAIL sat_ovf_sticky: got ovf=%b, want 1", ovf);
      end
      step(1'b0, 1'b1);
      n_cmp++;
      if (ovf !== 1'b0 || pending !== 3'd0) begin
         n_err++;
         $display("FAIL sat_clr: got ovf=%b pending=%0d, want ovf=0 pending=0", ovf, pending);
      end
   endtask

   // Strobe on the last gap cycle (cycle 16) must restart HIGH at cycle 17.
   task automatic test_back_to_back;
      logic [6:0] exp_z;
      step(1'b1, 1'b0);
      for (int i = 0; i < 5; i++) step(1'b0, 1'b0);
      n_cmp++;
      if (z !== 1'b0 || busy !== 1'b1) begin
         n_err++;
         $display("FAIL b2b_gap: got z=%b busy=%b, want z=0 busy=1", z, busy);
      end
      exp_z = 7'b0001111;
      step(1'b1, 1'b0);
      for (int i = 0; i < 7; i++) begin
         n_cmp++;
         if (z !== exp_z[i] || busy !== (i < 6) || pending !== 3'd0) begin
            n_err++;
            $display("FAIL b2b cyc%0d: got z=%b busy=%b pending=%0d, want z=%b busy=%b pending=0",
                     17 + i, z, busy, pending, exp_z[i], (i < 6));
         end
         step(1'b0, 1'b0);
      end
   endtask

   // clr with w in the same cycle, while HIGH with three queued events.
   task automatic test_clr;
      int rises;
      logic prev_z;
      step(1'b1, 1'b0);
      step(1'b1, 1'b0);
      step(1'b1, 1'b0);
      step(1'b1, 1'b0);
      n_cmp++;
      if (z !== 1'b1 || pending !== 3'd3) begin
         n_err++;
         $display("FAIL clr_setup: got z=%b pending=%0d, want z=1 pending=3", z, pending);
      end
      step(1'b1, 1'b1);
      n_cmp++;
      if (z !== 1'b0 || pending !== 3'd0 || ovf !== 1'b0 || busy !== 1'b0) begin
         n_err++;
         $display("FAIL clr_effect: got z=%b pending=%0d ovf=%b busy=%b, want all 0", z, pending, ovf, busy);
      end
      rises  = 0;
      prev_z = 1'b0;
      for (int i = 0; i < 20; i++) begin
         step(1'b0, 1'b0);
         if (z && !prev_z) rises++;
         prev_z = z;
      end
      n_cmp++;
      if (rises != 0) begin
         n_err++;
         $display("FAIL clr_no_beeps: got %0d beeps after clr, want 0", rises);
      end
   endtask

   // Asynchronous reset in the middle of a gap cycle with two queued events.
   task automatic test_async_reset;
      step(1'b1, 1'b0);
      step(1'b1, 1'b0);
      step(1'b1, 1'b0);
      step(1'b0, 1'b0);
      step(1'b0, 1'b0);
      n_cmp++;
      if (z !== 1'b0 || busy !== 1'b1 || pending !== 3'd2) begin
         n_err++;
         $display("FAIL areset_setup: got z=%b busy=%b pending=%0d, want z=0 busy=1 pending=2", z, busy, pending);
      end
      #2;
      reset = 1'b1;
      #1;
      n_cmp++;
      if ({z, busy, pending, ovf} !== 6'b0) begin
         n_err++;
         $display("FAIL areset_immediate: got z=%b busy=%b pending=%0d ovf=%b, want all 0", z, busy, pending, ovf);
      end
      #2;
      reset = 1'b0;
      for (int i = 0; i < 8; i++) begin
         step(1'b0, 1'b0);
         n_cmp++;
         if (z !== 1'b0 || busy !== 1'b0 || pending !== 3'd0) begin
            n_err++;
            $display("FAIL areset_idle cyc%0d: got z=%b busy=%b pending=%0d, want all 0", i, z, busy, pending);
         end
      end
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      test_reset();
      for (int i = 0; i < 9; i++) step(1'b0, 1'b0);
      test_single();
      test_three();
      test_saturate();
      test_back_to_back();
      test_clr();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
